wb_port_arbiter: RTL
====================

Name: wb_port_arbiter

Overview:
- Schedules the single register-file write port among three write-back sources: ALU result (src0), load data (src1) and link address PC+4 (src2).
- Each source hands off over a valid/ready handshake into a one-entry holding buffer.
- A round-robin arbiter drains one buffer per cycle into a registered write port.
- `wb_sel_o` reports the granted source for the write-back select and for debug; sits between EX/MEM and the register file.

Parameters:
- DW, 32, data width of every source and of the write port
- AW, 5, register address width

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- src0_valid_i  in  1  ALU result valid
- src0_data_i  in  DW  ALU result
- src0_addr_i  in  AW  ALU destination register
- src0_ready_o  out  1  src0 buffer can accept
- src1_valid_i / src1_data_i / src1_addr_i / src1_ready_o  same as src0, for load data
- src2_valid_i / src2_data_i / src2_addr_i / src2_ready_o  same as src0, for link address
- rf_we_o  out  1  register-file write enable
- rf_waddr_o  out  AW  write address
- rf_wdata_o  out  DW  write data
- wb_sel_o  out  2  granted source index (0/1/2); write-back mux select encoding
- busy_o  out  1  any holding buffer occupied

Behaviour:
- Reset (async, rst_i=1):
  - All buffers empty, `last_grant`=2.
  - `rf_we_o`=0, `rf_waddr_o`=0, `rf_wdata_o`=0, `wb_sel_o`=0, `busy_o`=0.
  - Reset mid-operation discards all buffered writes; none reach the write port.
- Per-source buffer state: `full[i]`, `data[i]`, `addr[i]`.
- Accept:
  - Occurs when `srcN_valid_i & srcN_ready_o` at a rising edge; data/addr captured.
  - `srcN_ready_o` = `~full[N] | grant[N]`, combinational from state only; never depends on `valid_i`.
  - Drain and refill of the same buffer on one edge is legal; buffer stays full with new contents.
- Arbitration (combinational, current cycle):
  - Candidates are the full buffers.
  - Priority order starts at (`last_grant`+1) mod 3 and wraps.
  - At most one grant per cycle.
  - On grant, `last_grant` ← granted index at the next edge; otherwise it is unchanged.
- Write port (registered):
  - At the edge following a grant: `rf_we_o`=1, `rf_waddr_o`=`addr[g]`, `rf_wdata_o`=`data[g]`, `wb_sel_o`=g, and `full[g]` cleared.
  - With no grant: `rf_we_o`=0; `rf_waddr_o`/`rf_wdata_o`/`wb_sel_o` hold their last values.
- Register $zero:
  - An entry with addr=0 is accepted and granted normally, but produces `rf_we_o`=0 for that cycle.
  - `wb_sel_o` still updates; `last_grant` still advances.
- Latency: accept at edge E → `rf_we_o` high in the cycle after edge E+1, when uncontended (2 edges).
- Worst-case wait: 2 grants to other sources before a full buffer is granted.
- Starvation-free.
- Ordering: no ordering is enforced across sources; the issuing pipeline guarantees no two in-flight writes to the same register.
- `busy_o` = OR of `full[0..2]`, combinational.

Optional Feature:
- Macro: `WB_SCOREBOARD_EN`.
- Defined: adds ports
  - `chk_addr_i`  in  AW  query address
  - `chk_hit_o`  out  1  combinational; 1 iff any full buffer has addr == `chk_addr_i` and `chk_addr_i` ≠ 0, or `rf_we_o`=1 with `rf_waddr_o` == `chk_addr_i`.
  - The decoder uses `chk_hit_o` to stall on a pending write.
- Undefined: ports absent; no comparators.

Test Plan:
- Reset: rst_i pulsed during activity → all outputs 0 within the reset cycle; `srcN_ready_o`=1 after release.
- Single write: src0 valid, data=0x0000_1234, addr=8, one cycle → `rf_we_o`=1, `rf_waddr_o`=8, `rf_wdata_o`=0x1234, `wb_sel_o`=0 exactly 2 edges later, then `rf_we_o`=0.
- Three-way contention from reset: all three valid in one cycle with addrs 1/2/3 → writes on consecutive cycles in order `wb_sel_o`=0,1,2; addrs 1,2,3; `busy_o` drops after the third grant.
- Back-pressure: src1 held valid 4 cycles with distinct data while src0 and src2 are also continuously valid → src1 granted once per 3 cycles; `src1_ready_o`=1 only in its grant cycles; no data lost or duplicated.
- $zero: src2 addr=0, data=0xFFFF_FFFF → `rf_we_o` stays 0; `wb_sel_o`=2; `last_grant` advances, so a following src0 vs src1 contention grants src0 first.
- Scoreboard (`WB_SCOREBOARD_EN`): src1 accepted with addr=9, `chk_addr_i`=9 → `chk_hit_o`=1 through the write cycle and 0 the cycle after; `chk_addr_i`=0 → always 0.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: three valid/ready sources, one-entry buffers, round-robin drain to a registered RF write port.
// Optional `WB_SCOREBOARD_EN adds a pending-write lookup (chk_addr_i / chk_hit_o).
module wb_port_arbiter #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          src0_valid_i,
    input  logic [DW-1:0] src0_data_i,
    input  logic [AW-1:0] src0_addr_i,
    output logic          src0_ready_o,
    input  logic          src1_valid_i,
    input  logic [DW-1:0] src1_data_i,
    input  logic [AW-1:0] src1_addr_i,
    output logic          src1_ready_o,
    input  logic          src2_valid_i,
    input  logic [DW-1:0] src2_data_i,
    input  logic [AW-1:0] src2_addr_i,
    output logic          src2_ready_o,
    output logic          rf_we_o,
    output logic [AW-1:0] rf_waddr_o,
    output logic [DW-1:0] rf_wdata_o,
    output logic [1:0]    wb_sel_o,
    output logic          busy_o
`ifdef WB_SCOREBOARD_EN
    ,
    input  logic [AW-1:0] chk_addr_i,
    output logic          chk_hit_o
`endif
);

    localparam int unsigned NSRC = 3;

    logic [NSRC-1:0] full_q, full_d;
    logic [DW-1:0]   data_q [NSRC];
    logic [DW-1:0]   data_d [NSRC];
    logic [AW-1:0]   addr_q [NSRC];
    logic [AW-1:0]   addr_d [NSRC];
    logic [1:0]      last_q, last_d;

    logic            rf_we_q, rf_we_d;
    logic [AW-1:0]   rf_waddr_q, rf_waddr_d;
    logic [DW-1:0]   rf_wdata_q, rf_wdata_d;
    logic [1:0]      wb_sel_q, wb_sel_d;

    logic [NSRC-1:0] valid_c, ready_c, grant_c;
    logic [DW-1:0]   din_c [NSRC];
    logic [AW-1:0]   ain_c [NSRC];
    logic [1:0]      o0_c, o1_c, o2_c, g_c;
    logic            gnt_any_c;

    assign valid_c  = {src2_valid_i, src1_valid_i, src0_valid_i};
    assign din_c[0] = src0_data_i;
    assign din_c[1] = src1_data_i;
    assign din_c[2] = src2_data_i;
    assign ain_c[0] = src0_addr_i;
    assign ain_c[1] = src1_addr_i;
    assign ain_c[2] = src2_addr_i;

    // Round-robin search order begins just after the last granted source.
    always_comb begin
        o0_c = 2'd0;
        o1_c = 2'd1;
        o2_c = 2'd2;
        case (last_q)
            2'd0: begin o0_c = 2'd1; o1_c = 2'd2; o2_c = 2'd0; end
            2'd1: begin o0_c = 2'd2; o1_c = 2'd0; o2_c = 2'd1; end
            default: ;
        endcase
    end

    always_comb begin
        g_c       = 2'd0;
        gnt_any_c = 1'b1;
        if (full_q[o0_c])      g_c = o0_c;
        else if (full_q[o1_c]) g_c = o1_c;
        else if (full_q[o2_c]) g_c = o2_c;
        else                   gnt_any_c = 1'b0;
        grant_c = gnt_any_c ? 3'(3'b001 << g_c) : 3'b000;
    end

    // A buffer being drained this cycle may be refilled on the same edge.
    assign ready_c      = ~full_q | grant_c;
    assign src0_ready_o = ready_c[0];
    assign src1_ready_o = ready_c[1];
    assign src2_ready_o = ready_c[2];
    assign busy_o       = |full_q;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        addr_d = addr_q;
        last_d = last_q;
        if (gnt_any_c) begin
            full_d[g_c] = 1'b0;
            last_d      = g_c;
        end
        for (int i = 0; i < NSRC; i++) begin
            if (valid_c[i] && ready_c[i]) begin
                full_d[i] = 1'b1;
                data_d[i] = din_c[i];
                addr_d[i] = ain_c[i];
            end
        end
    end

    // Writes to $zero are granted and reported on wb_sel but never enabled.
    always_comb begin
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        wb_sel_d   = wb_sel_q;
        if (gnt_any_c) begin
            rf_we_d    = (addr_q[g_c] != '0);
            rf_waddr_d = addr_q[g_c];
            rf_wdata_d = data_q[g_c];
            wb_sel_d   = g_c;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            full_q     <= '0;
            data_q     <= '{default: '0};
            addr_q     <= '{default: '0};
            last_q     <= 2'd2;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            wb_sel_q   <= 2'd0;
        end else begin
            full_q     <= full_d;
            data_q     <= data_d;
            addr_q     <= addr_d;
            last_q     <= last_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            wb_sel_q   <= wb_sel_d;
        end
    end

    assign rf_we_o    = rf_we_q;
    assign rf_waddr_o = rf_waddr_q;
    assign rf_wdata_o = rf_wdata_q;
    assign wb_sel_o   = wb_sel_q;

`ifdef WB_SCOREBOARD_EN
    // Pending write to chk_addr_i either still buffered or on the port this cycle.
    always_comb begin
        chk_hit_o = rf_we_q && (rf_waddr_q == chk_addr_i);
        for (int i = 0; i < NSRC; i++) begin
            if (full_q[i] && (addr_q[i] == chk_addr_i) && (chk_addr_i != '0)) chk_hit_o = 1'b1;
        end
    end
`endif

endmodule
